// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO registers for the EX stage.
// Multiplication uses an external combinational signed 32x32 multiplier.
// This block registers the multiplier operands and captures the product
// MULT_LAT cycles after the op is accepted.
// Division is a 32-cycle restoring divider that works on operand magnitudes.
// One final cycle (DFIX) then applies the result signs.
// MTHI/MTLO write a register in a single cycle.
// busy (equal to !op_ready) lets the hazard unit stall MFHI/MFLO and any new HI/LO op.
module hilo_unit #(
  parameter int MULT_LAT = 2  // legal range 1..8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        op_ready,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DFIX
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [4:0] MUL_CNT_INIT = 5'(MULT_LAT - 1);
  localparam logic [4:0] DIV_CNT_INIT = 5'd31;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic        mulu_q, mulu_d;     // product needs the unsigned correction
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rem_q, rem_d;       // partial remainder (always < divisor)
  logic [31:0] dvd_q, dvd_d;       // dividend bits shift out MSB first, quotient bits shift in
  logic [31:0] dvs_q, dvs_d;       // divisor magnitude
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dbz_q, dbz_d;       // divide by zero: LO is forced to all ones

  // Helper terms: operand magnitudes, one restoring step, multiply and divide fix-ups.
  logic        div_signed;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] rem_shift;
  logic        rem_fits;
  logic [31:0] rem_sub;
  logic [31:0] mulu_hi;
  logic [31:0] fix_hi, fix_lo;

  always_comb begin
    div_signed = (op == OP_DIV);
    rs_neg     = div_signed & rs_val[31];
    rt_neg     = div_signed & rt_val[31];
    rs_mag     = rs_neg ? (32'd0 - rs_val) : rs_val;
    rt_mag     = rt_neg ? (32'd0 - rt_val) : rt_val;

    // 33-bit partial remainder: the previous remainder with the next dividend bit appended.
    rem_shift  = {rem_q, dvd_q[31]};
    rem_fits   = (rem_shift >= {1'b0, dvs_q});
    rem_sub    = rem_shift[31:0] - dvs_q;

    // The signed product becomes unsigned by adding each operand when the other's MSB is set.
    mulu_hi    = mul_hi
               + (mul_a_q[31] ? mul_b_q : 32'd0)
               + (mul_b_q[31] ? mul_a_q : 32'd0);

    fix_lo     = dbz_q  ? 32'hFFFF_FFFF
               : (qneg_q ? (32'd0 - dvd_q) : dvd_q);
    fix_hi     = rneg_q ? (32'd0 - rem_q) : rem_q;
  end

  // Next-state logic: op accept, multiply countdown, divide iteration, sign fix-up.
  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    mulu_d  = mulu_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;

    if (flush) begin
      // Cancel whatever is in flight; HI/LO and the multiplier operands keep their values.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            unique case (op)
              OP_MULT, OP_MULTU: begin
                mul_a_d = rs_val;
                mul_b_d = rt_val;
                mulu_d  = op[0];
                cnt_d   = MUL_CNT_INIT;
                state_d = S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                dvd_d   = rs_mag;
                dvs_d   = rt_mag;
                rem_d   = 32'd0;
                qneg_d  = rs_neg ^ rt_neg;
                rneg_d  = rs_neg;
                dbz_d   = (rt_val == 32'd0);
                cnt_d   = DIV_CNT_INIT;
                state_d = S_DIV;
              end
              OP_MTHI: hi_d = rs_val;
              OP_MTLO: lo_d = rs_val;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt_q == 5'd0) begin
            hi_d    = mulu_q ? mulu_hi : mul_hi;
            lo_d    = mul_lo;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_DIV: begin
          rem_d = rem_fits ? rem_sub : rem_shift[31:0];
          dvd_d = {dvd_q[30:0], rem_fits};
          if (cnt_q == 5'd0) begin
            state_d = S_DFIX;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_DFIX: begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register; reset clears all state immediately, mid-operation included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
      mulu_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      rem_q   <= 32'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop updates from its pre-edge value.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      mulu_q  <= mulu_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign op_ready = ~busy;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Testbench for hilo_unit.
// A table of directed HI/LO ops is run through the DUT, which is paired with
// a behavioural signed 32x32 multiplier.
// Hand-written sequences follow for stall/flush, a held op and asynchronous reset.
module tb_hilo_unit;

  localparam int MULT_LAT = 2;
  localparam int DIV_LAT  = 33;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic        op_ready;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  hilo_unit #(.MULT_LAT(MULT_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_hi   (mul_hi),
    .mul_lo   (mul_lo),
    .op_ready (op_ready),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  // External combinational signed multiplier.
  logic signed [63:0] ext_a, ext_b, prod;
  assign ext_a  = {{32{mul_a[31]}}, mul_a};
  assign ext_b  = {{32{mul_b[31]}}, mul_b};
  assign prod   = ext_a * ext_b;
  assign mul_hi = prod[63:32];
  assign mul_lo = prod[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int tests = 0;
  int fails = 0;
  logic [31:0] prev_hi, prev_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op, count busy cycles (bounded), then check HI/LO.
  // HI/LO must hold their old values until completion.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    logic early;
    @(negedge clk);
    check($sformatf("v%0d op_ready_before", idx), 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op       = v.op;
    rs_val   = v.rs;
    rt_val   = v.rt;
    @(negedge clk);
    op_valid = 1'b0;
    cyc   = 0;
    early = 1'b0;
    while (busy === 1'b1 && cyc < 200) begin
      if (hi !== prev_hi || lo !== prev_lo) early = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check($sformatf("v%0d busy_cycles", idx), 32'(cyc), 32'(v.lat));
    check($sformatf("v%0d early_update", idx), 32'(early), 32'd0);
    check($sformatf("v%0d hi", idx), hi, v.exp_hi);
    check($sformatf("v%0d lo", idx), lo, v.exp_lo);
    prev_hi = v.exp_hi;
    prev_lo = v.exp_lo;
  endtask

  initial begin
    int cyc;
    logic stall_ok;

    //            op      rs             rt             exp_hi         exp_lo         lat
    vecs[0]  = '{3'b000, 32'd10,        32'd10,        32'd0,         32'd100,       MULT_LAT};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF,  32'd5,         32'd4,         32'hFFFFFFFB,  MULT_LAT};
    vecs[2]  = '{3'b000, 32'hFFFFFFFF,  32'd5,         32'hFFFFFFFF,  32'hFFFFFFFB,  MULT_LAT};
    vecs[3]  = '{3'b000, 32'hFFFFFFFE,  32'hFFFFFFFD,  32'd0,         32'd6,         MULT_LAT};
    vecs[4]  = '{3'b001, 32'h80000000,  32'h80000000,  32'h40000000,  32'd0,         MULT_LAT};
    vecs[5]  = '{3'b010, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFD,  DIV_LAT};
    vecs[6]  = '{3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT};
    vecs[7]  = '{3'b011, 32'd5,         32'd0,         32'd5,         32'hFFFFFFFF,  DIV_LAT};
    vecs[8]  = '{3'b010, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  DIV_LAT};
    vecs[9]  = '{3'b010, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  32'hFFFFFFFF,  DIV_LAT};
    vecs[10] = '{3'b010, 32'd7,         32'hFFFFFFFE,  32'd1,         32'hFFFFFFFD,  DIV_LAT};
    vecs[11] = '{3'b001, 32'h80000000,  32'd3,         32'd1,         32'h80000000,  MULT_LAT};
    vecs[12] = '{3'b100, 32'h1234,      32'd0,         32'h1234,      32'h80000000,  0};
    vecs[13] = '{3'b101, 32'h5678,      32'd0,         32'h1234,      32'h5678,      0};
    vecs[14] = '{3'b111, 32'hFFFF,      32'hFFFF,      32'h1234,      32'h5678,      0};

    rst_n    = 1'b1;
    op_valid = 1'b0;
    op       = 3'b000;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    flush    = 1'b0;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset op_ready", 32'(op_ready), 32'd1);
    check("reset mul_a", mul_a, 32'd0);
    check("reset mul_b", mul_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    prev_hi = 32'd0;
    prev_lo = 32'd0;
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // DIV followed by a held MTHI: the MTHI must stall.
    // A flush on cycle 10 cancels the DIV.
    @(negedge clk);
    op_valid = 1'b1;
    op       = 3'b010;
    rs_val   = 32'd100;
    rt_val   = 32'd7;
    @(negedge clk);
    op     = 3'b100;
    rs_val = 32'hDEAD;
    check("flush_seq busy_after_accept", 32'(busy), 32'd1);
    stall_ok = 1'b1;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (op_ready !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678) stall_ok = 1'b0;
    end
    check("flush_seq stalled", 32'(stall_ok), 32'd1);
    flush    = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_seq busy", 32'(busy), 32'd0);
    check("flush_seq op_ready", 32'(op_ready), 32'd1);
    check("flush_seq hi", hi, 32'h1234);
    check("flush_seq lo", lo, 32'h5678);
    check("flush_seq mul_a_hold", mul_a, 32'h80000000);
    check("flush_seq mul_b_hold", mul_b, 32'd3);

    // A held op is accepted on the first edge after busy drops.
    @(negedge clk);
    op_valid = 1'b1;
    op       = 3'b011;
    rs_val   = 32'd100;
    rt_val   = 32'd7;
    @(negedge clk);
    op     = 3'b100;
    rs_val = 32'hDEAD;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("held busy_cycles", 32'(cyc), 32'(DIV_LAT));
    check("held div hi", hi, 32'd2);
    check("held div lo", lo, 32'd14);
    @(negedge clk);
    op_valid = 1'b0;
    check("held mthi hi", hi, 32'hDEAD);
    check("held mthi lo", lo, 32'd14);
    check("held mthi busy", 32'(busy), 32'd0);

    // flush together with an op in IDLE: the op must not be accepted.
    @(negedge clk);
    flush    = 1'b1;
    op_valid = 1'b1;
    op       = 3'b101;
    rs_val   = 32'h9999;
    @(negedge clk);
    flush    = 1'b0;
    op_valid = 1'b0;
    check("flush_idle lo", lo, 32'd14);
    check("flush_idle busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a MULT.
    @(negedge clk);
    op_valid = 1'b1;
    op       = 3'b000;
    rs_val   = 32'd7;
    rt_val   = 32'd9;
    @(negedge clk);
    op_valid = 1'b0;
    check("rst_mid busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid hi", hi, 32'd0);
    check("rst_mid lo", lo, 32'd0);
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid mul_a", mul_a, 32'd0);
    check("rst_mid mul_b", mul_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    run_vec('{3'b000, 32'd5, 32'd3, 32'd0, 32'd15, MULT_LAT}, 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sits in the EX stage of the MIPS core, downstream of the combinational 32x32 multiplier. Owns the architectural HI/LO registers.
- Drives the multiplier's operands and captures its 64-bit product after a fixed latency.
- Adds a 32-cycle iterative divider, MTHI/MTLO writes, and a busy interlock that the hazard unit uses to stall MFHI/MFLO and new HI/LO ops.

Parameters:
- MULT_LAT, 2, cycles from op accept to HI/LO update for MULT/MULTU (legal range 1..8).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  decoded HI/LO op present this cycle
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are a no-op
- rs_val  in  32  first operand (dividend, multiplicand, or MTHI/MTLO data)
- rt_val  in  32  second operand (divisor or multiplier)
- flush  in  1  synchronous cancel of any in-flight mult/div
- mul_a  out  32  registered operand A to the multiplier
- mul_b  out  32  registered operand B to the multiplier
- mul_hi  in  32  multiplier product [63:32], signed product of mul_a*mul_b
- mul_lo  in  32  multiplier product [31:0]
- op_ready  out  1  equals !busy; op accepted on a clk edge where op_valid && op_ready && !flush
- busy  out  1  mult/div in flight
- hi  out  32  HI register, read combinationally by MFHI
- lo  out  32  LO register, read combinationally by MFLO

Behaviour:
- Reset (rst_n low, asynchronous): hi=0, lo=0, busy=0, mul_a=0, mul_b=0, FSM=IDLE, divider state cleared. Takes effect mid-operation with no completion.
- FSM states: IDLE, MUL, DIV, DFIX.
- IDLE + accepted MULT/MULTU:
  - Latch mul_a=rs_val, mul_b=rt_val and the signedness flag.
  - Load the counter with MULT_LAT-1 and go to MUL; busy=1 from the next cycle.
- MUL: decrement the counter each cycle. At the edge where it reads 0:
  - Capture hi/lo, go to IDLE, busy drops.
  - Net timing: accept at edge k, hi/lo valid after edge k+MULT_LAT; busy high for MULT_LAT cycles.
- MULTU correction (product from the multiplier is signed):
  - hi = mul_hi + (mul_a[31] ? mul_b : 0) + (mul_b[31] ? mul_a : 0), mod 2^32.
  - lo = mul_lo unchanged.
  - MULT captures mul_hi/mul_lo directly.
- IDLE + accepted DIV/DIVU:
  - Latch magnitudes of both operands (unsigned for DIVU), plus quotient sign (sa^sb) and remainder sign (sa).
  - Go to DIV with counter=31.
- DIV: one restoring iteration per cycle, a 33-bit partial remainder shifted against the dividend bits MSB first. After the iteration at counter 0, go to DFIX.
- DFIX: apply signs and write the result, then go to IDLE.
  - lo = quotient, negated if the quotient sign is set.
  - hi = remainder, negated if the remainder sign is set.
  - Net timing: accept at edge k, hi/lo valid after edge k+33; busy high for 33 cycles.
- Divide by zero (rt_val=0, DIV or DIVU): full 33-cycle latency, then hi=original rs_val, lo=32'hFFFFFFFF.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0; falls out of the magnitude algorithm with no special case.
- MTHI/MTLO, accepted in IDLE: hi (or lo) = rs_val at the accept edge. busy stays 0. The other register is unchanged.
- op_valid while busy: ignored, no state change. The pipeline holds the op until op_ready.
- flush:
  - Any state goes to IDLE at the next edge and busy=0.
  - hi/lo keep their pre-op values; mul_a/mul_b hold.
  - flush together with op_valid in IDLE: flush wins, the op is not accepted.
- MFHI/MFLO are external. hi/lo change only at the completion edge, never partially.

Test Plan:
- MULT, rs=10, rt=10 (MULT_LAT=2) -> busy=1 for 2 cycles; then hi=0, lo=100, op_ready=1.
- MULTU, rs=32'hFFFFFFFF, rt=5 -> hi=4, lo=32'hFFFFFFFB. Same operands with MULT -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFB.
- DIV, rs=32'hFFFFFFF9 (-7), rt=2 -> busy for exactly 33 cycles; lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIVU, rs=100, rt=7 -> lo=14, hi=2.
- DIVU, rs=5, rt=0 -> after 33 cycles hi=5, lo=32'hFFFFFFFF. DIV, rs=32'h80000000, rt=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- MTHI 32'h1234 then MTLO 32'h5678 -> hi=32'h1234, lo=32'h5678. Then start DIV with op_valid held high for a second op -> second op not accepted until busy=0. flush at cycle 10 of the DIV -> busy=0 next cycle, hi/lo still 32'h1234/32'h5678.
- rst_n pulsed low mid-MULT, between clock edges -> hi=0, lo=0, busy=0 immediately with no clock edge. Next MULT 5*3 -> lo=15, hi=0.
